serial_seq_tx: RTL and testbench
================================

# serial_seq_tx

Serial sequence transmitter: the transmit end of the single-bit serial links our sequence detectors monitor. Accepts a parallel WIDTH-bit frame through a valid/ready handshake and shifts it out MSB-first on a one-bit line, one bit per enabled clock. It can optionally prepend the 3-bit start marker 1-0-1 so a downstream "101" detector can delimit frames. Sits between a parallel producer and the serial line.

## Interface
- WIDTH, 8, frame length in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (low = reset asserted)
- bit_en  input  1  bit-rate strobe; the line advances only on cycles where bit_en=1
- load_valid  input  1  producer has a frame on load_data
- load_data  input  WIDTH  frame to transmit, MSB sent first
- load_ready  output  1  block can accept a frame this cycle
- data_out  output  1  serial line
- tx_active  output  1  data_out currently carries marker or frame bits
- done  output  1  one-cycle pulse on the final frame bit

## Operation
- One clock, one asynchronous active-low reset; all outputs are registered.
- Reset values: data_out=0, tx_active=0, done=0, load_ready=1, state=IDLE, shift register=0, counter=0.
- Accept: a frame is taken on a rising edge where load_valid=1 and load_ready=1. load_data is captured into the shift register at that edge. Any load_valid while load_ready=0 is ignored; nothing is queued.
- load_ready=1 only in IDLE.
- States:
  - IDLE: data_out=0, tx_active=0. On accept, go to PRE if the marker is enabled, else DATA.
  - PRE: emits 1, 0, 1 with a 2-bit index. After the third marker bit, go to DATA.
  - DATA: emits shift[WIDTH-1], shifts left with 0 fill, and counts 0..WIDTH-1. The counter is $clog2(WIDTH) bits wide and never wraps mid-frame. After bit WIDTH-1, return to IDLE.
- Bit advance:
  - A new bit is presented on data_out at a rising edge only where bit_en=1. Each bit holds until the next such edge.
  - The first bit (marker or MSB) is driven at the first bit_en edge at or after the accept edge. An accept edge with bit_en=1 drives the first bit at that same edge.
  - When bit_en=0, state, counter, shift register and data_out all hold.
- done=1 for exactly one clock: the clock in which the last frame bit first appears.
- IDLE is re-entered at the bit_en edge after the last frame bit. That edge sets data_out=0 and tx_active=0. Consecutive frames are therefore separated by at least one idle 0 bit.
- Reset asserted mid-frame: all registers return to their reset values immediately (asynchronous). The frame is dropped and is not resumed after reset.

## Timing
- Accept to first bit: 0 clocks if bit_en=1 at the accept edge, else the next bit_en edge.
- Frame occupies 3+WIDTH bit periods with the marker, WIDTH without, plus a minimum of 1 idle bit period.
- load_ready rises at the same edge that returns the block to IDLE. The earliest next accept is that edge's following clock.
- tx_active is high for exactly the marker and frame bit periods.

## Configuration
- SERIAL_SEQ_TX_PREAMBLE_EN defined: every frame is preceded by marker 1,0,1; the PRE state and its 2-bit index are present.
- Not defined: PRE state and index are removed; an accepted frame goes straight to DATA. All other behaviour is unchanged.

## Test plan
- Reset: hold rst=0 for 3 clocks with load_valid=1 -> data_out=0, tx_active=0, done=0, load_ready=1 throughout, no frame accepted.
- With PREAMBLE_EN, WIDTH=8, bit_en=1, load 8'hA5 -> data_out = 1,0,1,1,0,1,0,0,1,0,1 on 11 consecutive clocks, then 0; done high only on the 11th bit; tx_active high for exactly 11 clocks.
- Without PREAMBLE_EN, WIDTH=8, bit_en=1, load 8'h3C -> data_out = 0,0,1,1,1,1,0,0, then 0; load_ready returns to 1 at the 9th edge.
- bit_en asserted every 4th clock, load 8'h81 (no marker) -> each bit held exactly 4 clocks; sequence 1,0,0,0,0,0,0,1; done is a single-clock pulse.
- Busy ignore: load 8'hFF, then present load_valid with 8'h00 during bit 3 -> the line still sends 8'hFF completely; 8'h00 is accepted only after load_ready returns to 1.
- Reset mid-frame at bit 5 of 8'hA5 -> outputs are at reset values in the same cycle; after release with load_valid=0 the line stays 0 with no residual bits.

Source files
------------

// File: rtl/serial_seq_tx.sv
// Serial sequence transmitter: parallel frame in, MSB-first serial line out, one bit per bit_en.
// Optional 1-0-1 start marker before each frame when SERIAL_SEQ_TX_PREAMBLE_EN is defined.
module serial_seq_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             data_out,
  output logic             tx_active,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

`ifdef SERIAL_SEQ_TX_PREAMBLE_EN
  typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;
  logic [1:0] pre_idx, pre_idx_n;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] shift, shift_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             data_out_n, tx_active_n, done_n, load_ready_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shift      <= '0;
      cnt        <= '0;
`ifdef SERIAL_SEQ_TX_PREAMBLE_EN
      pre_idx    <= '0;
`endif
      data_out   <= 1'b0;
      tx_active  <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      state      <= state_n;
      shift      <= shift_n;
      cnt        <= cnt_n;
`ifdef SERIAL_SEQ_TX_PREAMBLE_EN
      pre_idx    <= pre_idx_n;
`endif
      data_out   <= data_out_n;
      tx_active  <= tx_active_n;
      done       <= done_n;
      load_ready <= load_ready_n;
    end
  end

  // tx_active doubles as "first bit already on the line": an accept without bit_en
  // parks in PRE/DATA with tx_active=0 until the next strobe emits the first bit.
  always_comb begin
    state_n      = state;
    shift_n      = shift;
    cnt_n        = cnt;
`ifdef SERIAL_SEQ_TX_PREAMBLE_EN
    pre_idx_n    = pre_idx;
`endif
    data_out_n   = data_out;
    tx_active_n  = tx_active;
    done_n       = 1'b0;
    load_ready_n = load_ready;
    case (state)
      IDLE: begin
        if (load_valid && load_ready) begin
          load_ready_n = 1'b0;
          shift_n      = load_data;
          cnt_n        = '0;
`ifdef SERIAL_SEQ_TX_PREAMBLE_EN
          state_n      = PRE;
          pre_idx_n    = '0;
          if (bit_en) begin
            data_out_n  = 1'b1;
            tx_active_n = 1'b1;
          end
`else
          state_n      = DATA;
          if (bit_en) begin
            data_out_n  = load_data[WIDTH-1];
            shift_n     = load_data << 1;
            tx_active_n = 1'b1;
          end
`endif
        end
      end
`ifdef SERIAL_SEQ_TX_PREAMBLE_EN
      PRE: begin
        if (bit_en) begin
          if (!tx_active) begin
            data_out_n  = 1'b1;
            tx_active_n = 1'b1;
          end else if (pre_idx == 2'd2) begin
            state_n    = DATA;
            data_out_n = shift[WIDTH-1];
            shift_n    = shift << 1;
            cnt_n      = '0;
          end else begin
            pre_idx_n  = pre_idx + 2'd1;
            data_out_n = (pre_idx != 2'd0);
          end
        end
      end
`endif
      DATA: begin
        if (bit_en) begin
          if (!tx_active) begin
            data_out_n  = shift[WIDTH-1];
            shift_n     = shift << 1;
            tx_active_n = 1'b1;
            cnt_n       = '0;
          end else if (cnt == LAST) begin
            state_n      = IDLE;
            data_out_n   = 1'b0;
            tx_active_n  = 1'b0;
            load_ready_n = 1'b1;
            cnt_n        = '0;
          end else begin
            data_out_n = shift[WIDTH-1];
            shift_n    = shift << 1;
            cnt_n      = cnt + CW'(1);
            done_n     = (cnt == PRE_LAST);
          end
        end
      end
      default: begin
        state_n      = IDLE;
        data_out_n   = 1'b0;
        tx_active_n  = 1'b0;
        load_ready_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_seq_tx.sv
// Self-checking bench for serial_seq_tx: directed frames plus random traffic against a
// queue-based bit-stream model. Follows SERIAL_SEQ_TX_PREAMBLE_EN like the design.
module tb_serial_seq_tx;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             bit_en = 1'b0;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic             load_ready, data_out, tx_active, done;

  serial_seq_tx #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .data_out(data_out),
    .tx_active(tx_active), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: an accepted frame becomes a queue of line bits; each strobe pops one,
  // and the strobe after the queue empties returns the line to idle.
  bit mq[$];
  bit m_busy, m_line, m_act, m_done;

`ifdef SERIAL_SEQ_TX_PREAMBLE_EN
  localparam bit MARKER = 1'b1;
`else
  localparam bit MARKER = 1'b0;
`endif

  task automatic model_reset();
    mq.delete();
    m_busy = 0; m_line = 0; m_act = 0; m_done = 0;
  endtask

  task automatic model_pop();
    m_line = mq.pop_front();
    m_act  = 1;
    m_done = (mq.size() == 0);
  endtask

  task automatic model_step(input bit lv, input logic [WIDTH-1:0] ld, input bit be);
    m_done = 0;
    if (!m_busy) begin
      if (lv) begin
        m_busy = 1;
        mq.delete();
        if (MARKER) begin mq.push_back(1); mq.push_back(0); mq.push_back(1); end
        for (int i = WIDTH - 1; i >= 0; i--) mq.push_back(ld[i]);
        if (be) model_pop();
      end
    end else if (be) begin
      if (mq.size() > 0) model_pop();
      else begin m_busy = 0; m_line = 0; m_act = 0; end
    end
  endtask

  task automatic check_outputs();
    check_eq("data_out",   data_out,   m_line);
    check_eq("tx_active",  tx_active,  m_act);
    check_eq("done",       done,       m_done);
    check_eq("load_ready", load_ready, !m_busy);
  endtask

  // One clock: drive inputs, advance model at the edge, sample 1 time unit later.
  task automatic step(input bit lv, input logic [WIDTH-1:0] ld, input bit be);
    load_valid = lv; load_data = ld; bit_en = be;
    @(posedge clk);
    model_step(lv, ld, be);
    #1;
    check_outputs();
  endtask

  logic [WIDTH-1:0] rx;
  int unsigned act_cnt, done_cnt;

  initial begin
    model_reset();
    // Reset held with load_valid asserted: nothing may be accepted.
    rst = 0; load_valid = 1; load_data = 8'hA5; bit_en = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_outputs();
    end
    rst = 1;

    // Directed frame at full rate; also reassemble the frame from the line.
    step(1, 8'hA5, 1);
    rx = '0; act_cnt = 1; done_cnt = 0;
    for (int i = 0; i < WIDTH + 6; i++) begin
      if (tx_active && !(MARKER && act_cnt <= 3)) rx = {rx[WIDTH-2:0], data_out};
      step(0, '0, 1);
      if (tx_active) act_cnt++;
      if (done) done_cnt++;
    end
    check_eq("reassembled_a5", rx, 8'hA5);
    check_eq("done_pulses_a5", done_cnt, 1);

    step(1, 8'h3C, 1);
    for (int i = 0; i < WIDTH + 5; i++) step(0, '0, 1);

    // bit_en every 4th clock, accept on a non-strobe clock.
    step(1, 8'h81, 0);
    for (int i = 0; i < 4 * (WIDTH + 5); i++) step(0, '0, (i % 4) == 3);

    // Busy ignore: a second frame offered from bit 3 onward waits for load_ready.
    step(1, 8'hFF, 1);
    step(0, '0, 1);
    for (int i = 0; i < WIDTH + 10; i++) step(1, 8'h00, 1);
    for (int i = 0; i < WIDTH + 6; i++) step(0, '0, 1);

    // Asynchronous reset mid-frame: outputs clear in the same cycle, no residue after.
    step(1, 8'hA5, 1);
    for (int i = 0; i < 4; i++) step(0, '0, 1);
    #2 rst = 0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk); rst = 1;
    for (int i = 0; i < WIDTH + 6; i++) step(0, '0, 1);

    // Random traffic with random strobe density.
    for (int i = 0; i < 2500; i++) begin
      int unsigned dens;
      dens = (i / 500) % 3;
      step($urandom_range(0, 3) == 0, WIDTH'($urandom),
           (dens == 0) ? 1'b1 : (dens == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
